dither_gen: RTL and testbench
=============================

Name: dither_gen

Overview:
- Parametrised dither source for the delta-sigma modulator loop. Runs NUM_SRC independent maximal-length XNOR LFSRs (lengths 20/21/22/23).
- Combines them into an RPDF, TPDF or multi-source near-Gaussian dither word. Shifts, saturates and registers the result for the quantiser input.
- Adds runtime mode select, enable/hold, per-LFSR seed loading with ack, and lockup detection/recovery.

Parameters:
- NUM_SRC, 4, number of active LFSRs (1..4).
- SRC_W, 16, low bits taken from each LFSR as a signed sample (<=20).
- SHIFT, 7, arithmetic right shift applied to the sum.
- OUT_W, 16, dither output width; result saturates to this range.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- en  in  1  advance LFSRs and pipeline; low = hold
- mode  in  2  0 off, 1 RPDF, 2 TPDF, 3 sum of all sources
- seed_load  in  1  one-cycle seed write strobe
- seed_idx  in  2  target LFSR for seed write
- seed_data  in  23  seed value, low L bits used
- seed_ack  out  1  one-cycle pulse, cycle after seed_load
- dith_o  out  OUT_W  signed dither sample
- dith_valid  out  1  dith_o holds a sample computed under en
- lockup_o  out  1  sticky: an all-ones state was caught

Behaviour:
- Reset (reset==0 at posedge):
  - LFSR defaults: L20=20'hABCDE, L21=21'h08FA82, L22=22'h13CBAF, L23=23'h3B113F.
  - dith_o=0, dith_valid=0, seed_ack=0, lockup_o=0.
  - Pipeline registers cleared. Reset mid-operation discards in-flight samples.
- Step (en=1): shift left by one. bit0 <= b[L-1] XNOR b[T-1], with taps (L,T) = (20,17), (21,19), (22,21), (23,18).
- Lockup: an LFSR whose current state is all ones loads its default seed instead of stepping, and lockup_o sets. lockup_o clears only on reset.
- Seed load: in the seed_load cycle, LFSR[seed_idx] <= seed_data[L-1:0], regardless of en. This takes priority over stepping; the other LFSRs step normally if en.
  - All-ones seed: load the default seed instead and set lockup_o.
  - seed_idx >= NUM_SRC: write ignored.
  - seed_ack pulses on the next cycle in every seed_load case.
- Stage 1 (on en): sample s_i = signed LFSR_i[SRC_W-1:0]. Register sum at SRC_W+2 bits, sign-extended, selected by mode:
  - 0: sum=0.
  - 1: s0.
  - 2: s0+s1 (s0 only if NUM_SRC=1).
  - 3: sum of s0..s(NUM_SRC-1).
- mode is sampled in stage 1, so a change takes effect on the next computed sample. There is no glitch or partial sample.
- Stage 2 (on en): dith_o <= sat_OUT_W(sum >>> SHIFT), arithmetic floor shift. Saturation limits are -2^(OUT_W-1) and 2^(OUT_W-1)-1; sign-extend if wider.
- Latency: 2 en-cycles from LFSR state to dith_o.
- dith_valid: rises on the 2nd consecutive en cycle after reset and stays high while en=1. It drops the cycle after en falls, with dith_o held. On en return it re-rises after 1 cycle, since stage 1 still holds a valid sample.
- en=0: LFSRs, stage 1 and dith_o hold. Seed writes still apply.

Decomposition:
- Shared package: default seeds, LFSR lengths, tap positions, mode encodings (DITH_OFF/RPDF/TPDF/SUM).
- Sub-module lfsr_xnor (params LEN, TAP, SEED) handles step, seed load and lockup recovery. It is instantiated NUM_SRC times via generate.

Test Plan:
- Reset low 2 cycles, release with en=1, mode=1 -> dith_valid=0 for one cycle. Then dith_o=16'hFF79 (-135), dith_valid=1.
- Same with mode=2 -> first dith_o=16'hFF6E (-146). With mode=3 -> 16'hFF28 (-216). With mode=0 -> 16'h0000, valid=1.
- OUT_W=8, SHIFT=0, mode=3 from reset -> first dith_o=8'h80 (saturated -128, raw -27570).
- seed_load=1, seed_idx=1, seed_data=23'h1FFFFF (all ones) -> L21=21'h08FA82, seed_ack pulse next cycle, lockup_o=1 until reset.
- en held low 5 cycles mid-stream -> dith_o frozen, dith_valid=0 after 1 cycle. On en=1, sequence resumes at the exact next value versus a golden model with no gap.
- Free-run L20 with en=1 for 2^20-1 steps from the default seed -> returns to 20'hABCDE, never all ones, lockup_o stays 0.

Source files
------------

// File: rtl/dither_gen_pkg.sv
// Shared constants for the dither generator: LFSR geometry, default seeds and mode encodings.
package dither_gen_pkg;

    localparam int unsigned MAX_SRC = 4;
    localparam int unsigned SEED_W  = 23;

    localparam int unsigned LFSR_LEN [MAX_SRC] = '{20, 21, 22, 23};
    localparam int unsigned LFSR_TAP [MAX_SRC] = '{17, 19, 21, 18};
    localparam logic [SEED_W-1:0] LFSR_SEED [MAX_SRC] =
        '{23'h0ABCDE, 23'h08FA82, 23'h13CBAF, 23'h3B113F};

    typedef enum logic [1:0] {
        DITH_OFF  = 2'd0,
        DITH_RPDF = 2'd1,
        DITH_TPDF = 2'd2,
        DITH_SUM  = 2'd3
    } dith_mode_e;

    // Number of LFSR samples summed for a mode, given the number of active sources.
    function automatic int unsigned src_count(dith_mode_e m, int unsigned n);
        int unsigned cnt;
        case (m)
            DITH_OFF:  cnt = 0;
            DITH_RPDF: cnt = 1;
            DITH_TPDF: cnt = (n > 1) ? 2 : 1;
            default:   cnt = n;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/dither_gen_lfsr_xnor.sv
// Maximal-length XNOR LFSR with seed load and all-ones lockup recovery.
module lfsr_xnor
    import dither_gen_pkg::*;
#(
    parameter int unsigned       LEN    = 20,
    parameter int unsigned       TAP    = 17,
    parameter logic [SEED_W-1:0] SEED   = 23'h0ABCDE,
    parameter int unsigned       SAMP_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              step_i,
    input  logic              load_i,
    input  logic [LEN-1:0]    load_data_i,
    output logic [SAMP_W-1:0] sample_o,
    output logic              lock_evt_c
);

    localparam logic [LEN-1:0] SEED_L = SEED[LEN-1:0];

    logic [LEN-1:0] state_q, state_d;

    // All-ones is the XNOR lockup state; it is replaced by the default seed wherever it appears.
    always_comb begin
        state_d    = state_q;
        lock_evt_c = 1'b0;
        if (load_i) begin
            if (&load_data_i) begin
                state_d    = SEED_L;
                lock_evt_c = 1'b1;
            end else begin
                state_d = load_data_i;
            end
        end else if (step_i) begin
            if (&state_q) begin
                state_d    = SEED_L;
                lock_evt_c = 1'b1;
            end else begin
                state_d = {state_q[LEN-2:0], ~(state_q[LEN-1] ^ state_q[TAP-1])};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SEED_L;
        end else begin
            state_q <= state_d;
        end
    end

    assign sample_o = state_q[SAMP_W-1:0];

endmodule

// File: rtl/dither_gen.sv
// Dither source: NUM_SRC XNOR LFSRs combined per mode, shifted and saturated over a two-stage pipeline.
module dither_gen
    import dither_gen_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned SRC_W   = 16,
    parameter int unsigned SHIFT   = 7,
    parameter int unsigned OUT_W   = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic                    seed_load,
    input  logic [1:0]              seed_idx,
    input  logic [SEED_W-1:0]       seed_data,
    output logic                    seed_ack,
    output logic signed [OUT_W-1:0] dith_o,
    output logic                    dith_valid,
    output logic                    lockup_o
);

    localparam int unsigned SUM_W = SRC_W + 2;
    localparam int unsigned EXT_W = (SUM_W > OUT_W) ? SUM_W : OUT_W;
    localparam logic signed [EXT_W-1:0] SAT_MAX = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = EXT_W'(-(64'sd1 <<< (OUT_W - 1)));

    logic signed [SRC_W-1:0] samp [NUM_SRC];
    logic [NUM_SRC-1:0]      lock_evt_c;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        localparam int unsigned LEN = LFSR_LEN[g];
        lfsr_xnor #(
            .LEN    (LEN),
            .TAP    (LFSR_TAP[g]),
            .SEED   (LFSR_SEED[g]),
            .SAMP_W (SRC_W)
        ) u_lfsr (
            .clk_i       (clock),
            .rst_ni      (reset),
            .step_i      (en),
            .load_i      (seed_load && (seed_idx == 2'(g))),
            .load_data_i (seed_data[LEN-1:0]),
            .sample_o    (samp[g]),
            .lock_evt_c  (lock_evt_c[g])
        );
    end

    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic                    v1_q, v1_d;
    logic signed [OUT_W-1:0] dith_q, dith_d;
    logic                    valid_q, valid_d;
    logic                    ack_q, lock_q;
    int unsigned             n_use;

    // Stage 1: mode-selected sum of the current LFSR samples.
    always_comb begin
        sum_d = sum_q;
        v1_d  = v1_q;
        n_use = src_count(dith_mode_e'(mode), NUM_SRC);
        if (en) begin
            sum_d = '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (i < n_use) begin
                    sum_d = sum_d + SUM_W'(samp[i]);
                end
            end
            v1_d = 1'b1;
        end
    end

    logic signed [SUM_W-1:0] shifted;
    logic signed [EXT_W-1:0] ext, clamped;

    // Stage 2: floor shift then clamp into the output range.
    always_comb begin
        shifted = sum_q >>> SHIFT;
        ext     = EXT_W'(shifted);
        if (ext > SAT_MAX) begin
            clamped = SAT_MAX;
        end else if (ext < SAT_MIN) begin
            clamped = SAT_MIN;
        end else begin
            clamped = ext;
        end
        dith_d  = dith_q;
        valid_d = 1'b0;
        if (en) begin
            dith_d  = OUT_W'(clamped);
            valid_d = v1_q;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sum_q   <= '0;
            v1_q    <= 1'b0;
            dith_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            lock_q  <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            v1_q    <= v1_d;
            dith_q  <= dith_d;
            valid_q <= valid_d;
            ack_q   <= seed_load;
            lock_q  <= lock_q | (|lock_evt_c);
        end
    end

    assign seed_ack   = ack_q;
    assign dith_o     = dith_q;
    assign dith_valid = valid_q;
    assign lockup_o   = lock_q;

endmodule

// File: tb/tb_dither_gen.sv
// Randomized bench for dither_gen against an arithmetic reference model; default and saturating configs.
module tb_dither_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [1:0]  mode;
    logic        seed_load;
    logic [1:0]  seed_idx;
    logic [22:0] seed_data;

    logic        ack_a, valid_a, lock_a;
    logic [15:0] dith_a;
    logic        ack_b, valid_b, lock_b;
    logic [7:0]  dith_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dither_gen dut (
        .clock(clk), .reset(rst_n), .en(en), .mode(mode),
        .seed_load(seed_load), .seed_idx(seed_idx), .seed_data(seed_data),
        .seed_ack(ack_a), .dith_o(dith_a), .dith_valid(valid_a), .lockup_o(lock_a)
    );

    dither_gen #(.OUT_W(8), .SHIFT(0)) dut_sat (
        .clock(clk), .reset(rst_n), .en(en), .mode(mode),
        .seed_load(seed_load), .seed_idx(seed_idx), .seed_data(seed_data),
        .seed_ack(ack_b), .dith_o(dith_b), .dith_valid(valid_b), .lockup_o(lock_b)
    );

    // Reference model state
    int unsigned LEN [4] = '{20, 21, 22, 23};
    int unsigned TAP [4] = '{17, 19, 21, 18};
    int unsigned DEF [4] = '{32'h0ABCDE, 32'h08FA82, 32'h13CBAF, 32'h3B113F};
    int unsigned m_lfsr [4];
    int m_sum, m_dith_a, m_dith_b;
    bit m_v1, m_valid, m_ack, m_lock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sample16(int unsigned s);
        int v = int'(s & 32'hFFFF);
        if (v >= 32768) v -= 65536;
        return v;
    endfunction

    function automatic int floor_div_pow2(int v, int sh);
        int d = 1 << sh;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic int sat_out(int v, int sh, int w);
        int q  = floor_div_pow2(v, sh);
        int hi = (1 << (w - 1)) - 1;
        int lo = -(1 << (w - 1));
        if (q > hi) return hi;
        if (q < lo) return lo;
        return q;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) m_lfsr[i] = DEF[i];
            m_sum = 0; m_v1 = 0; m_dith_a = 0; m_dith_b = 0;
            m_valid = 0; m_ack = 0; m_lock = 0;
        end else begin
            if (en) begin
                int nuse;
                int acc;
                m_dith_a = sat_out(m_sum, 7, 16);
                m_dith_b = sat_out(m_sum, 0, 8);
                m_valid  = m_v1;
                nuse = (mode == 2'd0) ? 0 : (mode == 2'd1) ? 1 : (mode == 2'd2) ? 2 : 4;
                acc = 0;
                for (int i = 0; i < nuse; i++) acc += sample16(m_lfsr[i]);
                m_sum = acc;
                m_v1  = 1;
            end else begin
                m_valid = 0;
            end
            m_ack = seed_load;
            for (int i = 0; i < 4; i++) begin
                int unsigned mask = (32'd1 << LEN[i]) - 1;
                int unsigned s    = m_lfsr[i];
                if (seed_load && (int'(seed_idx) == i)) begin
                    int unsigned d = 32'(seed_data) & mask;
                    if (d == mask) begin
                        m_lfsr[i] = DEF[i];
                        m_lock = 1;
                    end else begin
                        m_lfsr[i] = d;
                    end
                end else if (en) begin
                    if (s == mask) begin
                        m_lfsr[i] = DEF[i];
                        m_lock = 1;
                    end else begin
                        int unsigned fb = (((s >> (LEN[i] - 1)) & 1) == ((s >> (TAP[i] - 1)) & 1)) ? 1 : 0;
                        m_lfsr[i] = ((s << 1) | fb) & mask;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("dith",     32'(dith_a),  32'(m_dith_a) & 32'hFFFF);
        chk("valid",    32'(valid_a), 32'(m_valid));
        chk("ack",      32'(ack_a),   32'(m_ack));
        chk("lock",     32'(lock_a),  32'(m_lock));
        chk("sat_dith", 32'(dith_b),  32'(m_dith_b) & 32'hFF);
        chk("sat_valid",32'(valid_b), 32'(m_valid));
        chk("sat_lock", 32'(lock_b),  32'(m_lock));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; seed_load = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [1:0]  t_mode [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [15:0] t_e16  [4] = '{16'hFF79, 16'hFF6E, 16'hFF28, 16'h0000};
    logic [7:0]  t_e8   [4] = '{8'h80, 8'h80, 8'h80, 8'h00};
    logic [15:0] held;

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 2'd0;
        seed_load = 1'b0; seed_idx = 2'd0; seed_data = '0;

        do_reset();
        chk("rst_dith",  32'(dith_a),  32'h0);
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_ack",   32'(ack_a),   32'h0);
        chk("rst_lock",  32'(lock_a),  32'h0);

        // First sample out of reset for each mode
        for (int k = 0; k < 4; k++) begin
            do_reset();
            mode = t_mode[k];
            en   = 1'b1;
            tick();
            chk("first_valid_low", 32'(valid_a), 32'h0);
            tick();
            chk("first_dith",      32'(dith_a),  32'(t_e16[k]));
            chk("first_valid",     32'(valid_a), 32'h1);
            chk("first_sat_dith",  32'(dith_b),  32'(t_e8[k]));
        end

        mode = 2'd3;
        for (int k = 0; k < 10; k++) tick();

        // All-ones seed to L21 falls back to the default and sets lockup
        seed_load = 1'b1; seed_idx = 2'd1; seed_data = 23'h1FFFFF;
        tick();
        seed_load = 1'b0;
        chk("seed_ack_pulse", 32'(ack_a),  32'h1);
        chk("seed_lockup",    32'(lock_a), 32'h1);
        tick();
        chk("seed_ack_clear", 32'(ack_a),  32'h0);
        chk("lockup_sticky",  32'(lock_a), 32'h1);
        for (int k = 0; k < 6; k++) tick();

        // Hold with en low, then resume
        held = dith_a;
        en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("hold_dith",  32'(dith_a),  32'(held));
            chk("hold_valid", 32'(valid_a), 32'h0);
        end
        en = 1'b1;
        tick();
        chk("resume_valid", 32'(valid_a), 32'h1);
        for (int k = 0; k < 5; k++) tick();

        // Long free run from reset: no lockup should ever appear
        do_reset();
        en = 1'b1; mode = 2'd3;
        for (int k = 0; k < 3000; k++) tick();
        chk("freerun_nolock", 32'(lock_a), 32'h0);

        // Randomized traffic
        for (int k = 0; k < 4000; k++) begin
            en        = ($urandom_range(7) != 0);
            seed_load = ($urandom_range(19) == 0);
            seed_idx  = 2'($urandom_range(3));
            seed_data = 23'($urandom);
            if ($urandom_range(3) == 0) seed_data = '1;
            if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
            rst_n = ($urandom_range(499) != 0);
            tick();
        end
        rst_n = 1'b1; seed_load = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
